// File: rtl/clock_mode_ctrl.sv
// Mode/edit controller for a digital clock: steps through run, time-set and alarm-set
// modes and turns key presses, key auto-repeat and an edit timeout into increment actions.
module clock_mode_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       tick_1hz,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic       EN_work,
  output logic       EN_set,
  output logic [1:0] set_sel,
  output logic       hour_inc,
  output logic       min_inc,
  output logic [3:0] al_hr_tens,
  output logic [3:0] al_hr_ones,
  output logic [3:0] al_min_tens,
  output logic [3:0] al_min_ones
);

  typedef enum logic [2:0] {RUN, SET_HR, SET_MIN, AL_HR, AL_MIN} state_t;

  localparam logic [4:0] TIMEOUT_LAST = 5'd29;  // 30th idle tick forces RUN
  localparam logic [1:0] REPEAT_DELAY = 2'd2;   // ticks held before auto-repeat starts

  state_t     r_state;
  state_t     w_next;
  logic       r_mode_d;
  logic       r_inc_d;
  logic       r_rep_act;
  logic [1:0] r_rep_cnt;
  logic [4:0] r_to_cnt;
  logic [7:0] r_al_hr;
  logic [7:0] r_al_min;
  logic       r_en_work;
  logic       r_en_set;
  logic [1:0] r_set_sel;
  logic       r_hour_inc;
  logic       r_min_inc;

  logic w_mode_rise;
  logic w_inc_rise;
  logic w_in_set;
  logic w_timeout;
  logic w_rep_fire;
  logic w_act;

  function automatic logic [7:0] bcd_hr_inc(input logic [7:0] v);
    if (v == 8'h23)             return 8'h00;
    else if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
    else                        return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_min_inc(input logic [7:0] v);
    if (v == 8'h59)             return 8'h00;
    else if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
    else                        return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign w_mode_rise = key_mode & ~r_mode_d;
  assign w_inc_rise  = key_inc & ~r_inc_d;
  assign w_in_set    = (r_state != RUN);
  assign w_timeout   = w_in_set & tick_1hz & (r_to_cnt == TIMEOUT_LAST) & ~w_mode_rise & ~w_inc_rise;
  assign w_rep_fire  = r_rep_act & key_inc & tick_1hz & (r_rep_cnt == REPEAT_DELAY);
  assign w_act       = (w_inc_rise & w_in_set) | w_rep_fire;

  always_comb begin
    w_next = RUN;
    case (r_state)
      RUN:     w_next = SET_HR;
      SET_HR:  w_next = SET_MIN;
      SET_MIN: w_next = AL_HR;
      AL_HR:   w_next = AL_MIN;
      default: w_next = RUN;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= RUN;
      r_mode_d   <= 1'b1;  // a key held through reset must not look like a fresh press
      r_inc_d    <= 1'b1;
      r_rep_act  <= 1'b0;
      r_rep_cnt  <= '0;
      r_to_cnt   <= '0;
      r_al_hr    <= 8'h07;
      r_al_min   <= 8'h00;
      r_en_work  <= 1'b0;
      r_en_set   <= 1'b1;
      r_set_sel  <= 2'b00;
      r_hour_inc <= 1'b0;
      r_min_inc  <= 1'b0;
    end else begin
      r_mode_d   <= key_mode;
      r_inc_d    <= key_inc;
      r_hour_inc <= 1'b0;
      r_min_inc  <= 1'b0;
      r_en_work  <= (r_state == SET_HR) || (r_state == SET_MIN);
      r_en_set   <= !((r_state == SET_HR) || (r_state == SET_MIN));
      case (r_state)
        RUN:     r_set_sel <= 2'b00;
        SET_HR:  r_set_sel <= 2'b01;
        SET_MIN: r_set_sel <= 2'b10;
        default: r_set_sel <= 2'b11;
      endcase

      if (w_mode_rise) begin
        r_state   <= w_next;
        r_to_cnt  <= '0;
        r_rep_act <= 1'b0;
        r_rep_cnt <= '0;
      end else if (w_timeout) begin
        r_state   <= RUN;
        r_to_cnt  <= '0;
        r_rep_act <= 1'b0;
        r_rep_cnt <= '0;
      end else begin
        if (w_inc_rise)                r_to_cnt <= '0;
        else if (w_in_set && tick_1hz) r_to_cnt <= r_to_cnt + 5'd1;

        if (w_inc_rise && w_in_set) begin
          r_rep_act <= 1'b1;
          r_rep_cnt <= '0;
        end else if (!key_inc) begin
          r_rep_act <= 1'b0;
          r_rep_cnt <= '0;
        end else if (r_rep_act && tick_1hz && (r_rep_cnt != REPEAT_DELAY)) begin
          r_rep_cnt <= r_rep_cnt + 2'd1;
        end

        if (w_act) begin
          case (r_state)
            SET_HR:  r_hour_inc <= 1'b1;
            SET_MIN: r_min_inc  <= 1'b1;
            AL_HR:   r_al_hr    <= bcd_hr_inc(r_al_hr);
            AL_MIN:  r_al_min   <= bcd_min_inc(r_al_min);
            default: ;
          endcase
        end
      end
    end
  end

  assign EN_work     = r_en_work;
  assign EN_set      = r_en_set;
  assign set_sel     = r_set_sel;
  assign hour_inc    = r_hour_inc;
  assign min_inc     = r_min_inc;
  assign al_hr_tens  = r_al_hr[7:4];
  assign al_hr_ones  = r_al_hr[3:0];
  assign al_min_tens = r_al_min[7:4];
  assign al_min_ones = r_al_min[3:0];

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed scenarios plus random key/tick traffic, all checked
// cycle by cycle against an integer-level model of the mode/alarm behaviour.
module tb_clock_mode_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       key_mode = 1'b0;
  logic       key_inc = 1'b0;
  logic       EN_work;
  logic       EN_set;
  logic [1:0] set_sel;
  logic       hour_inc;
  logic       min_inc;
  logic [3:0] al_hr_tens;
  logic [3:0] al_hr_ones;
  logic [3:0] al_min_tens;
  logic [3:0] al_min_ones;

  clock_mode_ctrl dut (
    .CLK(CLK), .RST(RST), .tick_1hz(tick_1hz), .key_mode(key_mode), .key_inc(key_inc),
    .EN_work(EN_work), .EN_set(EN_set), .set_sel(set_sel),
    .hour_inc(hour_inc), .min_inc(min_inc),
    .al_hr_tens(al_hr_tens), .al_hr_ones(al_hr_ones),
    .al_min_tens(al_min_tens), .al_min_ones(al_min_ones)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int n_hour  = 0;
  int n_min   = 0;

  // Model: mode index 0=RUN 1=SET_HR 2=SET_MIN 3=AL_HR 4=AL_MIN; alarm as plain integers.
  int m_mode, m_out_mode, m_idle, m_held, m_ah, m_am;
  bit m_rep_ok, m_kmp, m_kip, m_hp, m_mp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_out_mode = 0; m_idle = 0; m_held = 0;
    m_ah = 7; m_am = 0; m_rep_ok = 0; m_kmp = 1; m_kip = 1; m_hp = 0; m_mp = 0;
  endtask

  task automatic model_edge(input bit km, input bit ki, input bit t);
    bit me, ie, in_set, act;
    me = km && !m_kmp;
    ie = ki && !m_kip;
    in_set = (m_mode != 0);
    act = 0;
    m_out_mode = m_mode;
    if (me) begin
      m_mode = (m_mode + 1) % 5;
      m_idle = 0;
      m_rep_ok = 0;
    end else if (in_set && t && !ie && (m_idle + 1 >= 30)) begin
      m_mode = 0;
      m_idle = 0;
      m_rep_ok = 0;
    end else begin
      if (ie && in_set) begin
        act = 1; m_rep_ok = 1; m_held = 0;
      end else if (ki && m_rep_ok && t) begin
        m_held++;
        if (m_held > 2) act = 1;
      end
      if (!ki) m_rep_ok = 0;
      if (ie) m_idle = 0;
      else if (in_set && t) m_idle++;
    end
    m_hp = act && (m_out_mode == 1);
    m_mp = act && (m_out_mode == 2);
    if (act && m_out_mode == 3) m_ah = (m_ah + 1) % 24;
    if (act && m_out_mode == 4) m_am = (m_am + 1) % 60;
    m_kmp = km;
    m_kip = ki;
  endtask

  task automatic compare_all();
    int sel_exp;
    sel_exp = (m_out_mode >= 3) ? 3 : m_out_mode;
    check("set_sel", 32'(set_sel), sel_exp);
    check("en_work", 32'(EN_work), 32'(m_out_mode == 1 || m_out_mode == 2));
    check("en_set", 32'(EN_set), 32'(!(m_out_mode == 1 || m_out_mode == 2)));
    check("hour_inc", 32'(hour_inc), 32'(m_hp));
    check("min_inc", 32'(min_inc), 32'(m_mp));
    check("al_hr", 32'({al_hr_tens, al_hr_ones}), ((m_ah / 10) << 4) | (m_ah % 10));
    check("al_min", 32'({al_min_tens, al_min_ones}), ((m_am / 10) << 4) | (m_am % 10));
    if (hour_inc === 1'b1) n_hour++;
    if (min_inc === 1'b1) n_min++;
  endtask

  task automatic drive_edge(input bit km, input bit ki, input bit t);
    key_mode = km; key_inc = ki; tick_1hz = t;
    @(posedge CLK);
    model_edge(km, ki, t);
    #1;
    compare_all();
  endtask

  task automatic step(input bit km, input bit ki, input bit t);
    @(negedge CLK);
    drive_edge(km, ki, t);
  endtask

  task automatic do_reset(input bit ki_hold);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    key_mode = 1'b0; key_inc = ki_hold; tick_1hz = 1'b0;
    #1;
    check("rst_sel", 32'(set_sel), 0);
    check("rst_en_work", 32'(EN_work), 0);
    check("rst_en_set", 32'(EN_set), 1);
    check("rst_pulses", 32'({hour_inc, min_inc}), 0);
    check("rst_alarm", 32'({al_hr_tens, al_hr_ones, al_min_tens, al_min_ones}), 32'h0700);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    drive_edge(1'b0, ki_hold, 1'b0);
  endtask

  task automatic press_mode();
    step(1, 0, 0);
    step(0, 0, 0);
  endtask

  task automatic press_inc();
    step(0, 1, 0);
    step(0, 0, 0);
  endtask

  task automatic idle_tick();
    step(0, 0, 1);
    step(0, 0, 0);
  endtask

  initial begin
    int exp_sel[5];
    int exp_ew[5];
    int h0, m0;
    bit km, ki, t;
    exp_sel = '{1, 2, 3, 3, 0};
    exp_ew  = '{1, 1, 0, 0, 0};
    model_reset();

    // Mode sequence from reset
    do_reset(0);
    for (int i = 0; i < 5; i++) begin
      press_mode();
      check("seq_sel", 32'(set_sel), exp_sel[i]);
      check("seq_en_work", 32'(EN_work), exp_ew[i]);
    end

    // Alarm wrap: 23:59 -> 00:59 in AL_HR, then 00:00 in AL_MIN
    do_reset(0);
    repeat (3) press_mode();
    repeat (16) press_inc();
    press_mode();
    repeat (59) press_inc();
    check("alarm_2359", 32'({al_hr_tens, al_hr_ones, al_min_tens, al_min_ones}), 32'h2359);
    press_mode();
    repeat (3) press_mode();
    press_inc();
    check("hr_wrap", 32'({al_hr_tens, al_hr_ones, al_min_tens, al_min_ones}), 32'h0059);
    press_mode();
    press_inc();
    check("min_wrap", 32'({al_hr_tens, al_hr_ones, al_min_tens, al_min_ones}), 32'h0000);

    // Auto-repeat: key held over 5 ticks in SET_MIN
    do_reset(0);
    press_mode();
    press_mode();
    h0 = n_hour; m0 = n_min;
    step(0, 1, 0);
    repeat (5) begin
      step(0, 1, 1);
      step(0, 1, 0);
      step(0, 1, 0);
    end
    step(0, 0, 0);
    step(0, 0, 0);
    check("repeat_min", n_min - m0, 4);
    check("repeat_hour", n_hour - h0, 0);

    // Timeout after 30 idle ticks in SET_HR
    do_reset(0);
    press_mode();
    repeat (29) idle_tick();
    check("to_29_sel", 32'(set_sel), 1);
    step(0, 0, 1);
    step(0, 0, 0);
    check("to_30_sel", 32'(set_sel), 0);
    check("to_30_en_work", 32'(EN_work), 0);

    // Key press at tick 29 restarts the idle window
    do_reset(0);
    press_mode();
    repeat (28) idle_tick();
    press_inc();
    idle_tick();
    idle_tick();
    check("to_kept_sel", 32'(set_sel), 1);

    // Simultaneous mode and inc edges: mode wins
    do_reset(0);
    press_mode();
    h0 = n_hour;
    step(1, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("both_hour", n_hour - h0, 0);
    check("both_sel", 32'(set_sel), 2);

    // Reset mid-edit at alarm 12:34, inc key held through reset
    do_reset(0);
    repeat (3) press_mode();
    repeat (5) press_inc();
    press_mode();
    repeat (34) press_inc();
    check("alarm_1234", 32'({al_hr_tens, al_hr_ones, al_min_tens, al_min_ones}), 32'h1234);
    h0 = n_hour; m0 = n_min;
    do_reset(1);
    step(1, 1, 0);
    repeat (4) step(0, 1, 0);
    check("held_rst_hour", n_hour - h0, 0);
    check("held_rst_min", n_min - m0, 0);
    check("held_rst_sel", 32'(set_sel), 1);

    // Random traffic; every third segment keeps keys still so timeouts occur
    km = 0; ki = 0;
    do_reset(0);
    for (int seg = 0; seg < 40; seg++) begin
      if (seg % 7 == 6) do_reset(ki);
      for (int i = 0; i < 100; i++) begin
        if (seg % 3 != 0) begin
          if ($urandom_range(29) == 0) km = ~km;
          if ($urandom_range(11) == 0) ki = ~ki;
        end
        t = ($urandom_range(2) == 0);
        step(km, ki, t);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
